// File: rtl/synth_spi_pkg.sv
// Shared opcodes, frame lengths and FSM encoding for the SPI command decoder.
// SPI_CHECKSUM_EN adds the CHECK state used for the trailing XOR byte.
package synth_spi_pkg;

    localparam logic [7:0] OP_TUNE     = 8'h10;
    localparam logic [7:0] OP_NOTE_ON  = 8'h20;
    localparam logic [7:0] OP_NOTE_OFF = 8'h21;

    // Total bytes per frame including the opcode, excluding any checksum byte.
    localparam logic [2:0] LEN_TUNE     = 3'd6;
    localparam logic [2:0] LEN_NOTE_ON  = 3'd3;
    localparam logic [2:0] LEN_NOTE_OFF = 3'd2;

    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DISCARD = 3'd3
`ifdef SPI_CHECKSUM_EN
        , ST_CHECK = 3'd4
`endif
    } state_e;

    // Zero marks an opcode the decoder does not recognise.
    function automatic logic [2:0] frame_len(input logic [7:0] opcode);
        case (opcode)
            OP_TUNE:     return LEN_TUNE;
            OP_NOTE_ON:  return LEN_NOTE_ON;
            OP_NOTE_OFF: return LEN_NOTE_OFF;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_command_decoder_if.sv
// Raw mode-0 SPI slave pins; the master side drives them, the decoder side samples them.
interface spi_command_decoder_if;
    logic sclk;
    logic cs_n;
    logic mosi;

    modport master (output sclk, cs_n, mosi);
    modport slave  (input  sclk, cs_n, mosi);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus sclk-rise and cs_n rise/fall strobes in the clk_i domain.
module spi_sync_edge (
    input  logic                        clk_i,
    input  logic                        reset_i,
    spi_command_decoder_if.slave        bus,
    output logic                        sclk_rise_o,
    output logic                        cs_rise_o,
    output logic                        cs_fall_o,
    output logic                        cs_n_o,
    output logic                        mosi_o
);

    logic [1:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;
    logic       cs_prev_q;

    // cs_n resets to 0 so a frame already in progress at reset release never looks like
    // a falling edge; a new frame needs a real high-then-low on the pin.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[0], bus.cs_n};
            mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    assign sclk_rise_o = sclk_sync_q[1] & ~sclk_prev_q;
    assign cs_rise_o   = cs_sync_q[1] & ~cs_prev_q;
    assign cs_fall_o   = ~cs_sync_q[1] & cs_prev_q;
    assign cs_n_o      = cs_sync_q[1];
    assign mosi_o      = mosi_sync_q[1];

endmodule

// File: rtl/spi_command_decoder.sv
// Decodes TUNE / NOTE_ON / NOTE_OFF frames from a mode-0 SPI link into registered synth controls.
// Define SPI_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module spi_command_decoder
    import synth_spi_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_spi_sclk,
    input  logic        i_spi_cs_n,
    input  logic        i_spi_mosi,
    output logic        o_SPI_flag_dds,
    output logic        o_SPI_flag_adsr,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [6:0]  o_SPI_velocity,
    output logic        o_SPI_note_status,
    output logic        o_frame_error
);

    spi_command_decoder_if sif ();
    assign sif.sclk = i_spi_sclk;
    assign sif.cs_n = i_spi_cs_n;
    assign sif.mosi = i_spi_mosi;

    logic sclk_rise, cs_rise, cs_fall, cs_n_s, mosi_s;

    spi_sync_edge u_sync (
        .clk_i       (i_clk),
        .reset_i     (i_reset),
        .bus         (sif.slave),
        .sclk_rise_o (sclk_rise),
        .cs_rise_o   (cs_rise),
        .cs_fall_o   (cs_fall),
        .cs_n_o      (cs_n_s),
        .mosi_o      (mosi_s)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  voice_q, voice_d;
    logic [31:0] tune_q, tune_d;
    logic [6:0]  vel_q, vel_d;
`ifdef SPI_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
`endif

    logic        flag_dds_q, flag_dds_d;
    logic        flag_adsr_q, flag_adsr_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  out_voice_q, out_voice_d;
    logic [31:0] out_tune_q, out_tune_d;
    logic [6:0]  out_vel_q, out_vel_d;
    logic        note_q, note_d;

    logic        bit_strobe, byte_done, commit;
    logic [7:0]  rx_byte;

    assign bit_strobe = sclk_rise & ~cs_n_s & (state_q != ST_IDLE);
    assign byte_done  = bit_strobe & (bit_cnt_q == 3'd7);
    // The final bit is taken straight from the synchronizer so a completing byte commits on this edge.
    assign rx_byte    = {shift_q, mosi_s};

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        opcode_d    = opcode_q;
        voice_d     = voice_q;
        tune_d      = tune_q;
        vel_d       = vel_q;
`ifdef SPI_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        flag_dds_d  = 1'b0;
        flag_adsr_d = 1'b0;
        frame_err_d = 1'b0;
        out_voice_d = out_voice_q;
        out_tune_d  = out_tune_q;
        out_vel_d   = out_vel_q;
        note_d      = note_q;
        commit      = 1'b0;

        if (bit_strobe) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_OPCODE;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    shift_d    = '0;
                end
            end
            ST_OPCODE: begin
                if (byte_done) begin
                    if (frame_len(rx_byte) != 3'd0) begin
                        opcode_d = rx_byte;
                        state_d  = ST_PAYLOAD;
`ifdef SPI_CHECKSUM_EN
                        csum_d   = rx_byte;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_DISCARD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_done) begin
                    if (byte_cnt_q == 3'd1) begin
                        voice_d = rx_byte;
                    end else if (opcode_q == OP_TUNE) begin
                        tune_d = {tune_q[23:0], rx_byte};
                    end else begin
                        vel_d = rx_byte[6:0];
                    end
`ifdef SPI_CHECKSUM_EN
                    csum_d = csum_q ^ rx_byte;
`endif
                    if (byte_cnt_q == frame_len(opcode_q) - 3'd1) begin
`ifdef SPI_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        commit  = 1'b1;
                        state_d = ST_DISCARD;
`endif
                    end
                end
            end
`ifdef SPI_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_done) begin
                    if (rx_byte == csum_q) begin
                        commit = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_DISCARD;
                end
            end
`endif
            default: ;
        endcase

        // A select that ends before any bit arrived is harmless; anything later is an abort.
        if (cs_rise && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            commit      = 1'b0;
            frame_err_d = (state_q == ST_PAYLOAD)
`ifdef SPI_CHECKSUM_EN
                        || (state_q == ST_CHECK)
`endif
                        || ((state_q == ST_OPCODE) && (bit_cnt_q != 3'd0));
        end

        if (commit) begin
            out_voice_d = voice_d;
            case (opcode_q)
                OP_TUNE: begin
                    out_tune_d = tune_d;
                    flag_dds_d = 1'b1;
                end
                OP_NOTE_ON: begin
                    out_vel_d   = vel_d;
                    note_d      = 1'b1;
                    flag_adsr_d = 1'b1;
                end
                OP_NOTE_OFF: begin
                    note_d      = 1'b0;
                    flag_adsr_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            opcode_q    <= '0;
            voice_q     <= '0;
            tune_q      <= '0;
            vel_q       <= '0;
`ifdef SPI_CHECKSUM_EN
            csum_q      <= '0;
`endif
            flag_dds_q  <= 1'b0;
            flag_adsr_q <= 1'b0;
            frame_err_q <= 1'b0;
            out_voice_q <= '0;
            out_tune_q  <= '0;
            out_vel_q   <= '0;
            note_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            opcode_q    <= opcode_d;
            voice_q     <= voice_d;
            tune_q      <= tune_d;
            vel_q       <= vel_d;
`ifdef SPI_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            flag_dds_q  <= flag_dds_d;
            flag_adsr_q <= flag_adsr_d;
            frame_err_q <= frame_err_d;
            out_voice_q <= out_voice_d;
            out_tune_q  <= out_tune_d;
            out_vel_q   <= out_vel_d;
            note_q      <= note_d;
        end
    end

    assign o_SPI_flag_dds    = flag_dds_q;
    assign o_SPI_flag_adsr   = flag_adsr_q;
    assign o_frame_error     = frame_err_q;
    assign o_SPI_voice_index = out_voice_q;
    assign o_SPI_tuning_code = out_tune_q;
    assign o_SPI_velocity    = out_vel_q;
    assign o_SPI_note_status = note_q;

endmodule

// File: doc/spi_command_decoder.md
SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

Interface
REQ-001 The block SHALL have port i_clk, input, 1, the system clock; all logic is on its rising edge.
REQ-002 The block SHALL have port i_reset, input, 1, a synchronous active-high reset.
REQ-003 The block SHALL have port i_spi_sclk, input, 1, the asynchronous SPI clock (mode 0).
REQ-004 The block SHALL have port i_spi_cs_n, input, 1, the asynchronous active-low frame select.
REQ-005 The block SHALL have port i_spi_mosi, input, 1, the asynchronous serial data, MSB first.
REQ-006 The block SHALL have port o_SPI_flag_dds, output, 1, a one-cycle pulse: tuning word committed.
REQ-007 The block SHALL have port o_SPI_flag_adsr, output, 1, a one-cycle pulse: note event committed.
REQ-008 The block SHALL have port o_SPI_voice_index, output, 8, the target voice of the last committed frame.
REQ-009 The block SHALL have port o_SPI_tuning_code, output, 32, the last committed tuning word.
REQ-010 The block SHALL have port o_SPI_velocity, output, 7, the last committed NOTE_ON velocity.
REQ-011 The block SHALL have port o_SPI_note_status, output, 1, where 1 means NOTE_ON and 0 means NOTE_OFF.
REQ-012 The block SHALL have port o_frame_error, output, 1, a one-cycle pulse on an aborted or invalid frame.

Function
REQ-013 The block SHALL pass sclk, cs_n and mosi through 2-flop synchronizers, and detect sclk rising edges on the synchronized signal.
REQ-014 The block SHALL shift mosi in on each detected sclk rise while synchronized cs_n is 0; 8 bits form one byte.
REQ-015 The block SHALL support i_clk >= 8x sclk; slower i_clk SHALL be outside the contract.
REQ-016 The FSM SHALL have states IDLE, OPCODE, PAYLOAD, CHECK, DISCARD.
- IDLE -> OPCODE on cs_n falling.
- OPCODE -> PAYLOAD after byte 0.
- PAYLOAD -> CHECK, or commit, after the last payload byte.
- Any state -> IDLE on cs_n rising.
REQ-017 Opcodes and total byte counts (without checksum) SHALL be:
- 0x10 TUNE: voice, tuning[31:24..7:0]; 6 bytes.
- 0x20 NOTE_ON: voice, velocity; 3 bytes.
- 0x21 NOTE_OFF: voice; 2 bytes.
REQ-018 On commit, the affected data outputs SHALL update in the same cycle the flag pulses high for exactly 1 cycle.
- The pulse SHALL occur the cycle after the i_clk cycle that shifts in the final bit.
REQ-019 TUNE SHALL update voice_index and tuning_code and pulse flag_dds only.
REQ-020 NOTE_ON SHALL update voice_index, velocity (byte[6:0]; bit 7 ignored) and note_status=1, and pulse flag_adsr only.
REQ-021 NOTE_OFF SHALL update voice_index and note_status=0, pulse flag_adsr, and leave velocity unchanged.
REQ-022 Outputs not updated by a commit SHALL hold their previous values.
REQ-023 An unknown opcode SHALL cause one o_frame_error pulse, then DISCARD until cs_n goes high; nothing is committed.
REQ-024 cs_n rising before the frame completes (including mid-byte) SHALL abort the frame: o_frame_error pulses once, no commit, and partial bits are dropped.
REQ-025 Bytes after a completed frame within the same cs_n low period SHALL be ignored (DISCARD) with no error.
REQ-026 cs_n low with no sclk edges, followed by cs_n high, SHALL produce no error and no commit.
REQ-027 The flags SHALL never be asserted in the same cycle as each other.

Reset
REQ-028 Reset SHALL force all outputs to 0, the FSM to IDLE, and clear the shift register, bit counter and byte counter.
REQ-029 If reset occurs mid-frame, the block SHALL discard the remainder of the frame and accept a new frame only after cs_n has been seen high then low.

Configuration
REQ-030 When SPI_CHECKSUM_EN is defined, each frame SHALL carry one extra trailing byte equal to the XOR of all preceding bytes.
- CHECK state: on mismatch, o_frame_error pulses and nothing is committed.
- On match, the frame commits as in REQ-018 after the checksum byte.
REQ-031 When SPI_CHECKSUM_EN is undefined, there SHALL be no CHECK state, and the frame lengths in REQ-017 apply.

Structure
REQ-032 The shared package synth_spi_pkg SHALL hold:
- the opcode constants;
- per-opcode frame lengths;
- the FSM state enum;
- the checksum byte width.
REQ-033 The sub-module spi_sync_edge SHALL implement the synchronizers plus sclk-rise and cs_n-rise/fall detection.

Verification
REQ-034 TUNE test: send 10 05 12 34 56 78. Required: one flag_dds pulse, voice_index=0x05, tuning_code=0x12345678, flag_adsr stays 0.
REQ-035 NOTE_ON/NOTE_OFF test: send 20 03 FF, then 21 03. Required: velocity=0x7F and note_status=1, then note_status=0 with velocity still 0x7F; two flag_adsr pulses.
REQ-036 Abort test: raise cs_n after 10 05 12 plus 3 bits. Required: one o_frame_error pulse, no flag, outputs unchanged.
REQ-037 Unknown opcode test: send 7E 01 02. Required: one o_frame_error pulse, no flags; a following valid frame commits normally.
REQ-038 Checksum test with SPI_CHECKSUM_EN: send 21 09 28. Required: flag_adsr pulses. Send 21 09 29. Required: o_frame_error pulses and no flag.
REQ-039 Reset test: assert reset during byte 3 of a TUNE frame. Required: all outputs are 0, no flag, and the next full frame commits.
